// File: rtl/usb_keycode_queue.sv
// usb_keycode_queue: diffs committed HID boot-keyboard reports into a press/release event FIFO
//   Avalon-MM slave (address/chipselect/write/read/writedata/readdata, read latency 1):
//     0 KEYS_LO slots 0..3, 1 KEYS_HI slots 4..7, 2 COMMIT, 3 STATUS {busy,rollover,overflow,count}
//   evt_valid/evt_data/evt_ready: event stream {press, keycode}
//   key_state: held-key bitmap, present only when USB_KEYCODE_BITMAP_EN is defined
module usb_keycode_queue #(
  parameter int KEY_SLOTS = 6,
  parameter int DEPTH = 16,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   address,
  input  logic         chipselect,
  input  logic         write,
  input  logic         read,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  output logic         evt_valid,
  output logic [8:0]   evt_data,
  input  logic         evt_ready,
  output logic [255:0] key_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1;
  typedef enum logic [2:0] {IDLE, CHECK, REL, PRS, UPD} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [KEY_SLOTS-1:0][7:0] shadow_q, shadow_d, new_q, new_d, old_q, old_d;
  logic [31:0] rd_q, rd_d, st;
  logic ovf_q, ovf_d, rov_q, rov_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0] mem_q [DEPTH];
  logic [8:0] push_data;
  logic [63:0] sh;
  logic wr, rd, sw, last, has_err, hit, dup, push, push_ok, pop, full, ovf_set, rov_set;
  assign wr = chipselect & write;
  assign rd = chipselect & read;
  assign sw = wr && address == 2'd3;
  assign readdata = rd_q;
  assign evt_valid = cnt_q != '0;
  assign evt_data = evt_valid ? mem_q[rp_q] : '0;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    shadow_d = shadow_q;
    new_d = new_q;
    old_d = old_q;
    rov_set = 1'b0;
    push = 1'b0;
    push_data = '0;
    has_err = 1'b0;
    hit = 1'b0;
    dup = 1'b0;
    last = idx_q == IW'(KEY_SLOTS - 1);
    for (int i = 0; i < KEY_SLOTS; i++) begin
      if (wr && address == (i < 4 ? 2'd0 : 2'd1)) shadow_d[i] = writedata[8*(i%4) +: 8];
      has_err |= new_q[i] == 8'h01;
    end
    case (state_q)
      IDLE: if (wr && address == 2'd2) begin
        new_d = shadow_q;
        state_d = CHECK;
      end
      CHECK: begin
        idx_d = '0;
        rov_set = has_err;
        state_d = has_err ? IDLE : REL;
      end
      REL: begin
        // release only the first occurrence of an old key that vanished from the new report
        for (int j = 0; j < KEY_SLOTS; j++) begin
          hit |= new_q[j] == old_q[idx_q];
          dup |= (j < int'(idx_q)) && old_q[j] == old_q[idx_q];
        end
        push = old_q[idx_q] != 8'h00 && !hit && !dup;
        push_data = {1'b0, old_q[idx_q]};
        idx_d = last ? '0 : idx_q + IW'(1);
        state_d = last ? PRS : REL;
      end
      PRS: begin
        for (int j = 0; j < KEY_SLOTS; j++) begin
          hit |= old_q[j] == new_q[idx_q];
          dup |= (j < int'(idx_q)) && new_q[j] == new_q[idx_q];
        end
        push = new_q[idx_q] != 8'h00 && !hit && !dup;
        push_data = {1'b1, new_q[idx_q]};
        idx_d = last ? '0 : idx_q + IW'(1);
        state_d = last ? UPD : PRS;
      end
      UPD: begin
        old_d = new_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    full = cnt_q == CW'(DEPTH);
    pop = evt_valid & evt_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    push_ok = push & (!full | pop);
    ovf_set = push & full & !pop;
    wp_d = wp_q + AW'(push_ok);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d = (sw && writedata[16]) ? 1'b0 : ovf_q | ovf_set;
    rov_d = (sw && writedata[17]) ? 1'b0 : rov_q | rov_set;
    st = '0;
    st[CW-1:0] = cnt_q;
    st[16] = ovf_q;
    st[17] = rov_q;
    st[18] = state_q != IDLE;
    sh = 64'(shadow_q);
    rd_d = !rd ? rd_q : address == 2'd0 ? sh[31:0] : address == 2'd1 ? sh[63:32] : address == 2'd3 ? st : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      shadow_q <= '0;
      new_q <= '0;
      old_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
      rov_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      new_q <= new_d;
      old_q <= old_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
      rov_q <= rov_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= push_data;
  end
`ifdef USB_KEYCODE_BITMAP_EN
  logic [255:0] key_q, key_d;
  // bitmap follows generated events even when the FIFO drops them
  always_comb begin
    key_d = key_q;
    if (push) key_d[push_data[7:0]] = push_data[8];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) key_q <= '0;
    else key_q <= key_d;
  end
  assign key_state = key_q;
`else
  assign key_state = '0;
`endif
endmodule
